// File: rtl/tl_d_tracker_pkg.sv
// Shared types for the TileLink D-channel latency tracker: record layout,
// entry-table layout at default widths, and TileLink A opcodes.
package tl_d_tracker_pkg;

    localparam int SRC_W_DEF  = 4;
    localparam int USER_W_DEF = 4;
    localparam int LAT_W_DEF  = 16;

    localparam logic [2:0] A_PUT_FULL      = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL   = 3'd1;
    localparam logic [2:0] A_ARITH         = 3'd2;
    localparam logic [2:0] A_LOGICAL       = 3'd3;
    localparam logic [2:0] A_GET           = 3'd4;
    localparam logic [2:0] A_HINT          = 3'd5;
    localparam logic [2:0] A_ACQUIRE_BLOCK = 3'd6;
    localparam logic [2:0] A_ACQUIRE_PERM  = 3'd7;

    typedef struct packed {
        logic                 open;
        logic [2:0]           opcode;
        logic [LAT_W_DEF-1:0] age;
    } entry_t;

    typedef struct packed {
        logic [SRC_W_DEF-1:0]  source;
        logic [2:0]            opcode;
        logic [LAT_W_DEF-1:0]  latency;
        logic [USER_W_DEF-1:0] user;
        logic                  denied;
        logic                  corrupt;
        logic                  orphan;
    } tl_d_rec_t;

endpackage

// File: rtl/tl_d_latency_tracker_if.sv
// Monitored A/D beat signals plus the record output stream.
// rec stream: a record transfers on a cycle where rec_valid & rec_ready are
// both high; rec_valid never depends on rec_ready and rec_data holds while stalled.
interface tl_d_latency_tracker_if #(
    parameter int SRC_W  = 4,
    parameter int USER_W = 4,
    parameter int LAT_W  = 16
);
    localparam int REC_W = SRC_W + 3 + LAT_W + USER_W + 3;

    logic              a_fire;
    logic [SRC_W-1:0]  a_source;
    logic [2:0]        a_opcode;
    logic              a_first;
    logic              d_fire;
    logic [SRC_W-1:0]  d_source;
    logic              d_last;
    logic              d_denied;
    logic              d_corrupt;
    logic [USER_W-1:0] d_user;
    logic              rec_valid;
    logic              rec_ready;
    logic [REC_W-1:0]  rec_data;

    modport master (
        output a_fire, a_source, a_opcode, a_first,
        output d_fire, d_source, d_last, d_denied, d_corrupt, d_user,
        output rec_ready,
        input  rec_valid, rec_data
    );

    modport slave (
        input  a_fire, a_source, a_opcode, a_first,
        input  d_fire, d_source, d_last, d_denied, d_corrupt, d_user,
        input  rec_ready,
        output rec_valid, rec_data
    );
endinterface

// File: rtl/tl_d_rec_fifo.sv
// Registered synchronous FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module tl_d_rec_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop;
    logic             push_ok;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign data    = mem[rd_ptr];
    assign pop     = valid & ready;
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/tl_d_latency_tracker.sv
// Passive A/D pairing observer: times each source's outstanding request and
// emits one completion record per D-last beat into a small FIFO.
module tl_d_latency_tracker
    import tl_d_tracker_pkg::*;
#(
    parameter int SRC_W      = SRC_W_DEF,
    parameter int USER_W     = USER_W_DEF,
    parameter int LAT_W      = LAT_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    tl_d_latency_tracker_if.slave  bus,
    output logic [7:0]             drop_count,
    output logic [7:0]             reissue_count
);
    localparam int N     = 2 ** SRC_W;
    localparam int REC_W = SRC_W + 3 + LAT_W + USER_W + 3;

    typedef struct packed {
        logic             open;
        logic [2:0]       opcode;
        logic [LAT_W-1:0] age;
    } tbl_entry_t;

    tbl_entry_t       tbl [N];
    tbl_entry_t       d_entry;
    logic             a_open;
    logic             d_close;
    logic             same_src;
    logic             reissue;
    logic             rec_full;
    logic             rec_pop;
    logic             drop;
    logic [LAT_W-1:0] latency;
    logic [REC_W-1:0] rec;

    assign a_open   = bus.a_fire & bus.a_first;
    assign d_close  = bus.d_fire & bus.d_last;
    assign d_entry  = tbl[bus.d_source];
    assign latency  = (&d_entry.age) ? d_entry.age : d_entry.age + LAT_W'(1);
    assign same_src = d_close & (bus.d_source == bus.a_source);
    // A same-cycle close on this source empties the entry first, so it is not a reissue.
    assign reissue  = a_open & tbl[bus.a_source].open & ~same_src;
    assign rec_pop  = bus.rec_valid & bus.rec_ready;
    assign drop     = d_close & rec_full & ~rec_pop;

    assign rec = d_entry.open
        ? {bus.d_source, d_entry.opcode, latency, bus.d_user,
           bus.d_denied, bus.d_corrupt, 1'b0}
        : {bus.d_source, 3'd0, {LAT_W{1'b0}}, bus.d_user,
           bus.d_denied, bus.d_corrupt, 1'b1};

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) tbl[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (a_open && bus.a_source == SRC_W'(i)) begin
                    tbl[i] <= '{open: 1'b1, opcode: bus.a_opcode, age: '0};
                end else if (d_close && bus.d_source == SRC_W'(i)) begin
                    tbl[i].open <= 1'b0;
                end else if (tbl[i].open && !(&tbl[i].age)) begin
                    tbl[i].age <= tbl[i].age + LAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count    <= '0;
            reissue_count <= '0;
        end else begin
            if (drop && !(&drop_count))       drop_count    <= drop_count + 8'd1;
            if (reissue && !(&reissue_count)) reissue_count <= reissue_count + 8'd1;
        end
    end

    tl_d_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rec_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (d_close),
        .push_data (rec),
        .ready     (bus.rec_ready),
        .valid     (bus.rec_valid),
        .data      (bus.rec_data),
        .full      (rec_full)
    );
endmodule

// File: tb/tb_tl_d_latency_tracker.sv
// Directed bench for tl_d_latency_tracker: pairing, orphans, reissue,
// saturation, back-pressure and mid-flight reset.
module tb_tl_d_latency_tracker;
    import tl_d_tracker_pkg::*;

    localparam int REC_W = 30;

    logic       clock;
    logic       reset;
    logic [7:0] drop_count;
    logic [7:0] reissue_count;
    int         pass_cnt;
    int         total_cnt;

    tl_d_latency_tracker_if #(.SRC_W(4), .USER_W(4), .LAT_W(16)) bus ();

    tl_d_latency_tracker #(
        .SRC_W(4), .USER_W(4), .LAT_W(16), .FIFO_DEPTH(4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .drop_count    (drop_count),
        .reissue_count (reissue_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [REC_W-1:0] mk_rec(input logic [3:0] src, input logic [2:0] op,
                                                input logic [15:0] lat, input logic [3:0] user,
                                                input logic den, input logic cor, input logic orph);
        tl_d_rec_t r;
        r.source  = src;
        r.opcode  = op;
        r.latency = lat;
        r.user    = user;
        r.denied  = den;
        r.corrupt = cor;
        r.orphan  = orph;
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.a_fire    = 1'b0;
        bus.a_source  = '0;
        bus.a_opcode  = '0;
        bus.a_first   = 1'b1;
        bus.d_fire    = 1'b0;
        bus.d_source  = '0;
        bus.d_last    = 1'b1;
        bus.d_denied  = 1'b0;
        bus.d_corrupt = 1'b0;
        bus.d_user    = '0;
    endtask

    task automatic drive_a(input logic [3:0] src, input logic [2:0] op, input logic first);
        bus.a_fire   = 1'b1;
        bus.a_source = src;
        bus.a_opcode = op;
        bus.a_first  = first;
    endtask

    task automatic drive_d(input logic [3:0] src, input logic [3:0] user, input logic last,
                           input logic den, input logic cor);
        bus.d_fire    = 1'b1;
        bus.d_source  = src;
        bus.d_user    = user;
        bus.d_last    = last;
        bus.d_denied  = den;
        bus.d_corrupt = cor;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total_cnt++;
        if (bus.rec_valid !== 1'b0) $display("FAIL reset_rec_valid: got %b expected 0", bus.rec_valid);
        else pass_cnt++;
        total_cnt++;
        if (drop_count !== 8'd0) $display("FAIL reset_drop: got %0d expected 0", drop_count);
        else pass_cnt++;
        total_cnt++;
        if (reissue_count !== 8'd0) $display("FAIL reset_reissue: got %0d expected 0", reissue_count);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [REC_W-1:0] exp;
        drive_a(4'd3, A_GET, 1'b1); step(); idle();      // edge t
        step();                                           // t+1
        drive_d(4'd3, 4'h9, 1'b0, 1'b0, 1'b0); step(); idle();  // non-last D, t+2
        drive_a(4'd3, A_PUT_FULL, 1'b0); step(); idle();  // non-first A, t+3
        step(); step(); step();                           // t+4..t+6
        total_cnt++;
        if (bus.rec_valid !== 1'b0) $display("FAIL basic_no_early_rec: got %b expected 0", bus.rec_valid);
        else pass_cnt++;
        drive_d(4'd3, 4'h9, 1'b1, 1'b0, 1'b0); step(); idle();  // t+7
        total_cnt++;
        if (bus.rec_valid !== 1'b1) $display("FAIL basic_rec_valid: got %b expected 1", bus.rec_valid);
        else pass_cnt++;
        exp = mk_rec(4'd3, A_GET, 16'd7, 4'h9, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (bus.rec_data !== exp) $display("FAIL basic_rec_data: got %h expected %h", bus.rec_data, exp);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.rec_valid !== 1'b0) $display("FAIL basic_popped: got %b expected 0", bus.rec_valid);
        else pass_cnt++;
    endtask

    task automatic test_orphan();
        logic [REC_W-1:0] exp;
        drive_d(4'd5, 4'hA, 1'b1, 1'b1, 1'b0); step(); idle();
        exp = mk_rec(4'd5, 3'd0, 16'd0, 4'hA, 1'b1, 1'b0, 1'b1);
        total_cnt++;
        if (bus.rec_data !== exp || bus.rec_valid !== 1'b1)
            $display("FAIL orphan_rec: got v=%b %h expected v=1 %h", bus.rec_valid, bus.rec_data, exp);
        else pass_cnt++;
        total_cnt++;
        if (reissue_count !== 8'd0) $display("FAIL orphan_reissue: got %0d expected 0", reissue_count);
        else pass_cnt++;
        step();
    endtask

    task automatic test_overlap();
        logic [REC_W-1:0] exp;
        drive_a(4'd2, A_GET, 1'b1); step(); idle();        // c0
        step(); step(); step();                            // c1..c3
        drive_a(4'd2, A_PUT_PARTIAL, 1'b1); step(); idle(); // c4
        total_cnt++;
        if (reissue_count !== 8'd1) $display("FAIL reissue_count: got %0d expected 1", reissue_count);
        else pass_cnt++;
        step(); step(); step(); step();                    // c5..c8
        drive_d(4'd2, 4'h3, 1'b1, 1'b0, 1'b0); step(); idle(); // c9
        exp = mk_rec(4'd2, A_PUT_PARTIAL, 16'd5, 4'h3, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (bus.rec_data !== exp) $display("FAIL reissue_latency: got %h expected %h", bus.rec_data, exp);
        else pass_cnt++;
        step();
    endtask

    task automatic test_same_cycle();
        logic [REC_W-1:0] exp;
        drive_a(4'd6, A_GET, 1'b1); step(); idle();        // e0
        step(); step();                                    // e1, e2
        drive_a(4'd6, A_ARITH, 1'b1);
        drive_d(4'd6, 4'h1, 1'b1, 1'b0, 1'b1); step(); idle(); // e3
        exp = mk_rec(4'd6, A_GET, 16'd3, 4'h1, 1'b0, 1'b1, 1'b0);
        total_cnt++;
        if (bus.rec_data !== exp) $display("FAIL same_cycle_close: got %h expected %h", bus.rec_data, exp);
        else pass_cnt++;
        total_cnt++;
        if (reissue_count !== 8'd1) $display("FAIL same_cycle_reissue: got %0d expected 1", reissue_count);
        else pass_cnt++;
        step();                                            // e4
        drive_d(4'd6, 4'h2, 1'b1, 1'b0, 1'b0); step(); idle(); // e5
        exp = mk_rec(4'd6, A_ARITH, 16'd2, 4'h2, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (bus.rec_data !== exp) $display("FAIL same_cycle_reopen: got %h expected %h", bus.rec_data, exp);
        else pass_cnt++;
        step();
    endtask

    task automatic test_saturation();
        logic [REC_W-1:0] exp;
        drive_a(4'd1, A_GET, 1'b1); step(); idle();
        repeat (70000) step();
        drive_d(4'd1, 4'h5, 1'b1, 1'b0, 1'b0); step(); idle();
        exp = mk_rec(4'd1, A_GET, 16'hFFFF, 4'h5, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (bus.rec_data !== exp) $display("FAIL saturation: got %h expected %h", bus.rec_data, exp);
        else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [REC_W-1:0] exp;
        logic [3:0]       exp_src  [4];
        logic [3:0]       exp_user [4];
        exp_src  = '{4'd9, 4'd10, 4'd11, 4'd14};
        exp_user = '{4'h1, 4'h2, 4'h3, 4'hE};
        bus.rec_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_d(4'(8 + i), 4'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        idle();
        total_cnt++;
        if (drop_count !== 8'd2) $display("FAIL bp_drop_count: got %0d expected 2", drop_count);
        else pass_cnt++;
        exp = mk_rec(4'd8, 3'd0, 16'd0, 4'h0, 1'b0, 1'b0, 1'b1);
        total_cnt++;
        if (bus.rec_data !== exp || bus.rec_valid !== 1'b1)
            $display("FAIL bp_head: got v=%b %h expected v=1 %h", bus.rec_valid, bus.rec_data, exp);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.rec_data !== exp) $display("FAIL bp_head_stable: got %h expected %h", bus.rec_data, exp);
        else pass_cnt++;
        bus.rec_ready = 1'b1;
        drive_d(4'd14, 4'hE, 1'b1, 1'b0, 1'b0); step(); idle();
        total_cnt++;
        if (drop_count !== 8'd2) $display("FAIL bp_push_pop_full: got %0d expected 2", drop_count);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            exp = mk_rec(exp_src[i], 3'd0, 16'd0, exp_user[i], 1'b0, 1'b0, 1'b1);
            total_cnt++;
            if (bus.rec_data !== exp || bus.rec_valid !== 1'b1)
                $display("FAIL bp_drain_%0d: got v=%b %h expected v=1 %h", i, bus.rec_valid, bus.rec_data, exp);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (bus.rec_valid !== 1'b0) $display("FAIL bp_empty: got %b expected 0", bus.rec_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        logic [REC_W-1:0] exp;
        bus.rec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_a(4'(i), A_GET, 1'b1);
            step();
        end
        idle();
        drive_d(4'd9, 4'h0, 1'b1, 1'b0, 1'b0); step(); idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total_cnt++;
        if (bus.rec_valid !== 1'b0) $display("FAIL mid_reset_rec_valid: got %b expected 0", bus.rec_valid);
        else pass_cnt++;
        total_cnt++;
        if (drop_count !== 8'd0 || reissue_count !== 8'd0)
            $display("FAIL mid_reset_counters: got drop=%0d reissue=%0d expected 0 0", drop_count, reissue_count);
        else pass_cnt++;
        bus.rec_ready = 1'b1;
        drive_d(4'd2, 4'h7, 1'b1, 1'b0, 1'b0); step(); idle();
        exp = mk_rec(4'd2, 3'd0, 16'd0, 4'h7, 1'b0, 1'b0, 1'b1);
        total_cnt++;
        if (bus.rec_data !== exp || bus.rec_valid !== 1'b1)
            $display("FAIL mid_reset_orphan: got v=%b %h expected v=1 %h", bus.rec_valid, bus.rec_data, exp);
        else pass_cnt++;
        step();
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        reset         = 1'b1;
        bus.rec_ready = 1'b1;
        idle();
        test_reset();
        test_basic();
        test_orphan();
        test_overlap();
        test_same_cycle();
        test_saturation();
        test_back_to_back();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/tl_d_latency_tracker.md
# tl_d_latency_tracker

Passive TileLink observer that sits alongside the Insight data-bundle D-channel tap and consumes its D-channel beats, including the `user` field. It pairs each D response with the A request that opened it, matching on `source`. It times the transaction and pushes one completion record per response into a small output FIFO for the Insight trace encoder. It never drives or back-pressures the monitored TileLink link.

## Interface
Parameters:
- `SRC_W`, 4: source-ID width; tracker holds `2**SRC_W` entries.
- `USER_W`, 4: D-channel `user` width captured into records.
- `LAT_W`, 16: latency counter width; saturating.
- `FIFO_DEPTH`, 4: record FIFO depth; power of two, ≥2.

Ports:
- `clock`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high.
- `a_fire`  in  1: A-channel handshake (valid & ready) on the monitored link.
- `a_source`  in  SRC_W: source of the A beat.
- `a_opcode`  in  3: A opcode.
- `a_first`  in  1: first beat of the A message; only first beats open entries.
- `d_fire`  in  1: D-channel handshake on the monitored link.
- `d_source`  in  SRC_W: source of the D beat.
- `d_last`  in  1: last beat of the D message; only last beats close entries.
- `d_denied`, `d_corrupt`  in  1 each: D status bits.
- `d_user`  in  USER_W: D `user` field.
- `rec_valid`  out  1: record available.
- `rec_ready`  in  1: consumer accepts record.
- `rec_data`  out  SRC_W+3+LAT_W+USER_W+3: `{source, a_opcode, latency, user, denied, corrupt, orphan}`.
- `drop_count`  out  8: saturating count of records lost to a full FIFO.
- `reissue_count`  out  8: saturating count of A-first beats that hit an already-open source.

## Operation
- Entry table, one entry per source: `open`, `opcode[2:0]`, `age[LAT_W-1:0]`.
- **Open:** `a_fire & a_first` sets `open=1`, latches `opcode`, and sets `age=0`.
  - If the entry was already open, it is overwritten and `reissue_count` increments.
- **Aging:** each cycle, every open entry not being opened that cycle does `age <= age+1`, saturating at all-ones.
- **Close:** `d_fire & d_last` clears `open` and forms a record from the entry's `opcode` plus `age+1`, saturating, so an A-to-D gap of k cycles reports k.
- **Orphan:** a close on a non-open entry still forms a record, with `orphan=1`, `opcode=0`, `latency=0`.
- Non-last D beats and non-first A beats have no effect.
- **Same source, same cycle, A-first and D-last:** the close uses the pre-existing entry state, then the open installs the new entry; the result is open with `age=0`. `reissue_count` does not increment in this case.
- **Record FIFO:**
  - Push on close when not full.
  - When full, the record is discarded and `drop_count` increments, saturating at 255.
  - A pop (`rec_valid & rec_ready`) in the same cycle as a push into a full FIFO frees space, so the push succeeds and nothing is dropped.
- `rec_data` shows the FIFO head; it is stable while `rec_valid & !rec_ready`.
- **Reset:** all entries close, FIFO empties, counters clear, and `rec_valid=0`. A reset mid-transaction discards in-flight state; later D beats for those sources become orphans.

## Timing
- Close-to-record latency is 1 cycle: a D-last fire at cycle t gives `rec_valid=1` at t+1 if the FIFO was empty.
- The FIFO is registered, with no combinational path from `rec_ready` to `rec_valid`.
- Throughput: one record per cycle sustained when `rec_ready=1`.
- Counters update in the cycle after the triggering event.

## Structure
- Shared package `tl_d_tracker_pkg`:
  - `tl_d_rec_t` packed struct matching the `rec_data` order.
  - `entry_t` typedef.
  - TileLink A opcode localparams.
- Sub-module `tl_d_rec_fifo`: a generic synchronous valid/ready FIFO with a `full` flag and a push-when-full-with-pop rule.
- The entry table, aging and record formation stay in the top level.

## Test plan
- **Basic pairing:** A-first src 3, opcode Get(4) at cycle 10; D-last src 3 at cycle 17 → one record `{3,4,7,user,0,0,0}` at cycle 18.
- **Orphan:** D-last on src 5 with nothing open, `d_user=0xA` → record with `orphan=1`, `latency=0`, `user=0xA`; `reissue_count` unchanged.
- **Overlap and reissue:**
  - A-first src 2 at cycle 0 and again at cycle 4 → `reissue_count=1`; D-last at cycle 9 → latency 5.
  - A-first and D-last on src 6 in the same cycle, with an entry opened 3 cycles earlier → record latency 3, entry stays open with `age=0`, `reissue_count` unchanged.
- **Saturation:** hold src 1 open for 70000 cycles → latency `0xFFFF`.
- **Back-pressure:** hold `rec_ready=0`, close 6 sources on consecutive cycles → 4 records kept in order, `drop_count=2`.
  - Then assert a push and a pop in the same cycle on a full FIFO → no drop.
- **Reset mid-flight:** open src 0–3, pulse `reset` for 1 cycle → `rec_valid=0` and counters 0; a following D-last src 2 → orphan record.
